// File: rtl/or1k_spr_pkg.sv
// Shared types and constants for the OR1K SPR bus initiator.
// The optional bus timeout is enabled with the OR1K_SPR_TIMEOUT_EN macro.
package or1k_spr_pkg;

    localparam int SPR_ADDR_W          = 16;
    localparam int SPR_DATA_W          = 32;
    localparam int SPR_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } spr_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } spr_owner_t;

endpackage

// File: rtl/or1k_spr_initiator_if.sv
// Requester and SPR bus signals of the initiator, grouped for the master
// (initiator) and slave (environment) views.
interface or1k_spr_initiator_if;
    import or1k_spr_pkg::*;

    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [SPR_ADDR_W-1:0] cpu_addr_i;
    logic [SPR_DATA_W-1:0] cpu_dat_i;
    logic                  cpu_ack_o;
    logic [SPR_DATA_W-1:0] cpu_dat_o;
    logic                  cpu_err_o;

    logic                  dbg_req_i;
    logic                  dbg_we_i;
    logic [SPR_ADDR_W-1:0] dbg_addr_i;
    logic [SPR_DATA_W-1:0] dbg_dat_i;
    logic                  dbg_ack_o;
    logic [SPR_DATA_W-1:0] dbg_dat_o;

    logic                  spr_access_o;
    logic                  spr_we_o;
    logic                  spr_re_o;
    logic [SPR_ADDR_W-1:0] spr_addr_o;
    logic [SPR_DATA_W-1:0] spr_dat_o;
    logic                  spr_bus_ack_i;
    logic [SPR_DATA_W-1:0] spr_dat_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_dat_i,
        output cpu_ack_o, cpu_dat_o, cpu_err_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_dat_i,
        output dbg_ack_o, dbg_dat_o,
        output spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o,
        input  spr_bus_ack_i, spr_dat_i
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_dat_i,
        input  cpu_ack_o, cpu_dat_o, cpu_err_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_dat_i,
        input  dbg_ack_o, dbg_dat_o,
        input  spr_access_o, spr_we_o, spr_re_o, spr_addr_o, spr_dat_o,
        output spr_bus_ack_i, spr_dat_i
    );

endinterface

// File: rtl/or1k_spr_watchdog.sv
// Bus wait counter: flags expiry once TIMEOUT cycles have passed without an ack.
// Only instantiated when OR1K_SPR_TIMEOUT_EN is defined.
module or1k_spr_watchdog
    import or1k_spr_pkg::*;
#(
    parameter int TIMEOUT = SPR_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/or1k_spr_initiator.sv
// SPR bus initiator: arbitrates debug/CPU requests (debug first) and runs one
// SPR transaction at a time. Optional bus timeout: OR1K_SPR_TIMEOUT_EN.
module or1k_spr_initiator
    import or1k_spr_pkg::*;
#(
    parameter int OPTION_SPR_TIMEOUT = SPR_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    or1k_spr_initiator_if.master  spr
);

    if (OPTION_SPR_TIMEOUT < 2 || OPTION_SPR_TIMEOUT > 255) begin : g_bad_timeout
        $error("OPTION_SPR_TIMEOUT must be in 2..255");
    end

    spr_state_t            state;
    spr_owner_t            owner;
    logic                  we_q;
    logic [SPR_ADDR_W-1:0] addr_q;
    logic [SPR_DATA_W-1:0] wdat_q;
    logic [SPR_DATA_W-1:0] rdat_q;
    logic                  err_q;
    logic                  timeout;

`ifdef OR1K_SPR_TIMEOUT_EN
    or1k_spr_watchdog #(
        .TIMEOUT (OPTION_SPR_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != BUS),
        .enable  (state == BUS && !spr.spr_bus_ack_i),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // A bus ack in the same cycle as expiry completes normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= OWN_CPU;
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (spr.dbg_req_i) begin
                        owner  <= OWN_DBG;
                        we_q   <= spr.dbg_we_i;
                        addr_q <= spr.dbg_addr_i;
                        wdat_q <= spr.dbg_dat_i;
                        state  <= BUS;
                    end else if (spr.cpu_req_i) begin
                        owner  <= OWN_CPU;
                        we_q   <= spr.cpu_we_i;
                        addr_q <= spr.cpu_addr_i;
                        wdat_q <= spr.cpu_dat_i;
                        state  <= BUS;
                    end
                end
                BUS: begin
                    if (spr.spr_bus_ack_i) begin
                        rdat_q <= we_q ? '0 : spr.spr_dat_i;
                        err_q  <= 1'b0;
                        state  <= RESP;
                    end else if (timeout) begin
                        rdat_q <= '0;
                        err_q  <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic in_bus;
    logic in_resp;
    assign in_bus  = (state == BUS);
    assign in_resp = (state == RESP);

    assign spr.spr_access_o = in_bus;
    assign spr.spr_we_o     = in_bus & we_q;
    assign spr.spr_re_o     = in_bus & ~we_q;
    assign spr.spr_addr_o   = in_bus ? addr_q : '0;
    assign spr.spr_dat_o    = (in_bus && we_q) ? wdat_q : '0;

    assign spr.cpu_ack_o = in_resp && (owner == OWN_CPU);
    assign spr.cpu_dat_o = spr.cpu_ack_o ? rdat_q : '0;
    assign spr.cpu_err_o = spr.cpu_ack_o & err_q;
    assign spr.dbg_ack_o = in_resp && (owner == OWN_DBG);
    assign spr.dbg_dat_o = spr.dbg_ack_o ? rdat_q : '0;

endmodule

// File: tb/tb_or1k_spr_initiator.sv
// Directed bench for or1k_spr_initiator with a transaction-level scoreboard.
// Timeout scenarios run only when OR1K_SPR_TIMEOUT_EN is defined.
module tb_or1k_spr_initiator;

    typedef struct {
        bit          dbg;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        bit          err;
        int          bus_cycles;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cycle  = 0;

    exp_t        exp_q[$];
    int          slave_wait = 0;
    logic [31:0] slave_data = '0;
    int          slv_cnt;
    int          bus_cnt = 0;
    bit          prev_access = 0;

    or1k_spr_initiator_if bus ();

`ifdef OR1K_SPR_TIMEOUT_EN
    or1k_spr_initiator #(.OPTION_SPR_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .spr(bus));
`else
    or1k_spr_initiator dut (.clk(clk), .rst(rst), .spr(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Slave: acks after slave_wait bus cycles, drives slave_data on every bus cycle.
    assign bus.spr_bus_ack_i = bus.spr_access_o && (slv_cnt == slave_wait);
    assign bus.spr_dat_i     = bus.spr_access_o ? slave_data : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst)
            slv_cnt <= 0;
        else if (bus.spr_access_o && !bus.spr_bus_ack_i)
            slv_cnt <= slv_cnt + 1;
        else
            slv_cnt <= 0;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return {bus.cpu_ack_o, bus.cpu_dat_o, bus.cpu_err_o, bus.dbg_ack_o, bus.dbg_dat_o,
                bus.spr_access_o, bus.spr_we_o, bus.spr_re_o, bus.spr_addr_o, bus.spr_dat_o};
    endfunction

    // Scoreboard: every cycle, bus fields must match the transaction at the head of
    // the queue, acks must complete it with the right data, otherwise all outputs are 0.
    always @(negedge clk) begin
        if (rst) begin
            bus_cnt     = 0;
            prev_access = 0;
        end else if (bus.spr_access_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bus", 1, 0);
            end else begin
                check("bus_we",   bus.spr_we_o, exp_q[0].we);
                check("bus_re",   bus.spr_re_o, !exp_q[0].we);
                check("bus_addr", bus.spr_addr_o, exp_q[0].addr);
                check("bus_dat",  bus.spr_dat_o, exp_q[0].we ? exp_q[0].wdat : 32'h0);
                check("bus_noack", {bus.cpu_ack_o, bus.dbg_ack_o}, 2'b00);
            end
            bus_cnt++;
            prev_access = 1;
        end else if (bus.cpu_ack_o || bus.dbg_ack_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                logic [31:0] d;
                d = (exp_q[0].we || exp_q[0].err) ? 32'h0 : exp_q[0].rdat;
                check("ack_cpu",   bus.cpu_ack_o, !exp_q[0].dbg);
                check("ack_dbg",   bus.dbg_ack_o, exp_q[0].dbg);
                check("ack_cpu_dat", bus.cpu_dat_o, exp_q[0].dbg ? 32'h0 : d);
                check("ack_dbg_dat", bus.dbg_dat_o, exp_q[0].dbg ? d : 32'h0);
                check("ack_err",   bus.cpu_err_o, !exp_q[0].dbg && exp_q[0].err);
                check("ack_follows_bus", prev_access, 1);
                check("bus_cycles", bus_cnt, exp_q[0].bus_cycles);
                check("resp_bus_idle", {bus.spr_access_o, bus.spr_addr_o, bus.spr_dat_o}, 0);
                void'(exp_q.pop_front());
            end
            bus_cnt     = 0;
            prev_access = 0;
        end else begin
            check("idle_outputs", all_outputs(), 0);
            prev_access = 0;
        end
    end

    function automatic void expect_txn(input bit dbg, input bit we, input logic [15:0] addr,
                                       input logic [31:0] wdat, input logic [31:0] rdat,
                                       input bit err, input int bus_cycles);
        exp_t e;
        e.dbg = dbg; e.we = we; e.addr = addr; e.wdat = wdat;
        e.rdat = rdat; e.err = err; e.bus_cycles = bus_cycles;
        exp_q.push_back(e);
    endfunction

    task automatic applyStimulus(input bit is_dbg, input bit we, input logic [15:0] addr,
                                 input logic [31:0] dat, input logic [31:0] exp_dat,
                                 input bit exp_err, input int exp_lat);
        int start;
        bit seen;
        @(posedge clk);
        #1;
        if (is_dbg) begin
            bus.dbg_we_i = we; bus.dbg_addr_i = addr; bus.dbg_dat_i = dat; bus.dbg_req_i = 1'b1;
        end else begin
            bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_dat_i = dat; bus.cpu_req_i = 1'b1;
        end
        start = cycle;
        seen  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (is_dbg ? bus.dbg_ack_o : bus.cpu_ack_o) begin
                seen = 1;
                break;
            end
        end
        check(is_dbg ? "dbg_ack_seen" : "cpu_ack_seen", seen, 1);
        check(is_dbg ? "dbg_latency" : "cpu_latency", cycle - start, exp_lat);
        check(is_dbg ? "dbg_dat_lit" : "cpu_dat_lit",
              is_dbg ? bus.dbg_dat_o : bus.cpu_dat_o, exp_dat);
        if (!is_dbg) check("cpu_err_lit", bus.cpu_err_o, exp_err);
        @(posedge clk);
        #1;
        if (is_dbg) bus.dbg_req_i = 1'b0;
        else        bus.cpu_req_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_dat_i = '0;
        bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_addr_i = '0; bus.dbg_dat_i = '0;
        #3;
        check("reset_outputs", all_outputs(), 0);
        #20 rst = 1'b0;

        // 1: zero-wait CPU read
        slave_wait = 0; slave_data = 32'h0000_1234;
        expect_txn(0, 0, 16'h7801, 32'h0, 32'h0000_1234, 0, 1);
        applyStimulus(0, 0, 16'h7801, 32'h0, 32'h0000_1234, 0, 2);

        // 2: CPU write with three slave wait cycles; slave data must not leak back
        slave_wait = 3; slave_data = 32'hFFFF_0000;
        expect_txn(0, 1, 16'h7800, 32'hDEAD_BEEF, 32'h0, 0, 4);
        applyStimulus(0, 1, 16'h7800, 32'hDEAD_BEEF, 32'h0, 0, 5);

        // 3: simultaneous debug and CPU reads, debug served first
        slave_wait = 0; slave_data = 32'h0BAD_F00D;
        expect_txn(1, 0, 16'h0011, 32'h0, 32'h0BAD_F00D, 0, 1);
        expect_txn(0, 0, 16'h7802, 32'h0, 32'h0BAD_F00D, 0, 1);
        fork
            applyStimulus(1, 0, 16'h0011, 32'h0, 32'h0BAD_F00D, 0, 2);
            applyStimulus(0, 0, 16'h7802, 32'h0, 32'h0BAD_F00D, 0, 5);
        join

        // debug write with one wait cycle
        slave_wait = 1; slave_data = 32'h1357_9BDF;
        expect_txn(1, 1, 16'h0012, 32'hCAFE_F00D, 32'h0, 0, 2);
        applyStimulus(1, 1, 16'h0012, 32'hCAFE_F00D, 32'h0, 0, 3);

        // 4: reset in the middle of a CPU write
        slave_wait = 5; slave_data = 32'h0;
        expect_txn(0, 1, 16'h7804, 32'h1122_3344, 32'h0, 0, 6);
        @(posedge clk); #1;
        bus.cpu_we_i = 1; bus.cpu_addr_i = 16'h7804; bus.cpu_dat_i = 32'h1122_3344; bus.cpu_req_i = 1;
        @(posedge clk); @(posedge clk); #3;
        check("rst_mid_bus_active", bus.spr_access_o, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", all_outputs(), 0);
        exp_q.delete();
        bus.cpu_req_i = 0;
        @(posedge clk); #3 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_ack_after_rst", {bus.cpu_ack_o, bus.dbg_ack_o}, 2'b00);
        end
        slave_wait = 0; slave_data = 32'h0000_00A7;
        expect_txn(0, 0, 16'h7805, 32'h0, 32'h0000_00A7, 0, 1);
        applyStimulus(0, 0, 16'h7805, 32'h0, 32'h0000_00A7, 0, 2);

`ifdef OR1K_SPR_TIMEOUT_EN
        // 5: slave never acks, timeout after 4 bus cycles
        slave_wait = 255; slave_data = 32'h7777_7777;
        expect_txn(0, 0, 16'h7806, 32'h0, 32'h0, 1, 4);
        applyStimulus(0, 0, 16'h7806, 32'h0, 32'h0, 1, 5);

        // 6: ack on the expiry cycle wins
        slave_wait = 3; slave_data = 32'h5A5A_5A5A;
        expect_txn(0, 0, 16'h7807, 32'h0, 32'h5A5A_5A5A, 0, 4);
        applyStimulus(0, 0, 16'h7807, 32'h0, 32'h5A5A_5A5A, 0, 5);
`endif

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
